// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte-wide UART transmitter, LSB first, 8N1 (8E1 with UART_TX_PARITY_EN)
//
// Purpose: serialises one byte per valid/ready handshake onto an idle-high
// TX line at CLKS_PER_BIT clocks per bit. Defining UART_TX_PARITY_EN inserts
// an even-parity bit between the data bits and the stop bit.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   data  - byte to send, sampled on the handshake edge
//   valid - upstream offers a byte on data
//   ready - block accepts a byte this cycle (registered)
//   tx    - serial line out, idle high (registered)
//   busy  - high from start bit through stop bit (registered)
`timescale 1ns/1ps

module uart_tx #(
  parameter int CLK_HZ       = 100000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              bit_done;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign bit_done = (baud_q == BAUD_LAST);

  // State register; outputs are flops so the pad never sees a glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    // Baud counter free-runs within a frame and wraps on every bit boundary.
    if (state_q != S_IDLE) begin
      baud_d = bit_done ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (valid && ready_q) begin
          state_d  = S_START;
          shift_d  = data;
          baud_d   = '0;
          bit_d    = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data;
`endif
        end
      end
      S_START: begin
        if (bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state, so tx/ready/busy change on the same
  // edge as the state they belong to.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule
